pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central stall/flush controller for the five-stage MIPS pipeline (IF, ID, EX, MEM, WB). It collects stall requests from the instruction bus, the EX-stage multiply/divide unit and the data bus, and turns them into per-stage stall and flush (bubble) strobes. It drives the downstream-hold signal back into the multiply/divide unit and sequences exception redirects. It also keeps per-cause stall-cycle counters for performance readout.

## Interface
Parameters:
- `W_PERF`, 32: width of each stall counter.

Ports:
- `clk`  in  1  pipeline clock.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `if_req_stall`  in  1  instruction fetch outstanding; IF cannot complete.
- `ex_req_stall`  in  1  mul/div busy (the unit's `alu_stall`).
- `mem_req_stall`  in  1  data access outstanding; MEM cannot complete.
- `exc_req`  in  1  exception/ERET detected in MEM; level, held by MEM while stalled.
- `exc_target`  in  32  redirect PC for `exc_req`.
- `stall_if`, `stall_id`, `stall_ex`, `stall_mem`, `stall_wb`  out  1 each  stage register holds its value.
- `flush_id`, `flush_ex`, `flush_mem`, `flush_wb`  out  1 each  stage register loads a bubble.
- `ex_hold`  out  1  downstream hold to the mul/div unit's `reg_stall`.
- `redirect_valid`  out  1  PC loads `redirect_pc` this cycle.
- `redirect_pc`  out  32  latched exception target.
- `perf_sel`  in  2  counter select: 0 = IF, 1 = EX, 2 = MEM, 3 = exception cycles.
- `perf_data`  out  `W_PERF`  selected counter, combinational read.

## Operation
- FSM states: `RUN`, `PEND`, `FLUSH`. Reset state is `RUN`.
- In `RUN` with `exc_req`=0, the highest stalling stage wins (MEM > EX > IF):
  - MEM: `stall_if` through `stall_mem` = 1; `flush_wb` = 1.
  - EX: `stall_if`, `stall_id`, `stall_ex` = 1; `flush_mem` = 1.
  - IF: `stall_if` = 1; `flush_id` = 1.
  - None: all outputs 0.
- `ex_hold` = `stall_mem` (any cause). While EX is held from downstream, the mul/div unit keeps its completed result.
- `RUN` with `exc_req`=1:
  - Latch `exc_target`.
  - This cycle: `stall_if` through `stall_mem` = 1, `flush_wb` = 1, so the excepting instruction does not retire.
  - Next state: `PEND` if `if_req_stall`, else `FLUSH`.
  - `exc_req` overrides every stall-priority rule.
- `PEND`:
  - Outputs are the same as the exception cycle.
  - Stay while `if_req_stall`=1; go to `FLUSH` when it drops.
  - `exc_req` and `exc_target` are ignored.
- `FLUSH` (exactly 1 cycle):
  - `flush_id`, `flush_ex`, `flush_mem`, `flush_wb` = 1.
  - All stalls = 0.
  - `redirect_valid` = 1 and `redirect_pc` = latched target.
  - Next state is `RUN`. `exc_req` is not sampled in this cycle.
- Counters, all saturating-free and wrapping at 2^`W_PERF`:
  - Each counter increments by 1 per cycle in which its cause is the winning cause.
  - Cause 3 counts `PEND`, `FLUSH` and the exception-entry cycle.
  - At most one counter increments per cycle.

## Timing
- Stall and flush outputs are combinational from the inputs and the current state; there is no added latency.
- Exception: entry cycle N, then `FLUSH` at N+1 when the fetch is idle, so `redirect_valid` asserts one cycle after `exc_req`.
- Reset, including mid-exception:
  - State returns to `RUN`; all counters and `redirect_pc` = 0.
  - All outputs = 0 while `rst`=1.
- `redirect_valid` is never high in two consecutive cycles.

## Structure
- Shared package: the state enum (`RUN`/`PEND`/`FLUSH`), the `perf_sel` encodings and the stage-index constants.
- One natural sub-module, `stall_counters`: holds the four counters, the increment-select logic and the readout mux.

## Test plan
- Only `ex_req_stall`=1 for 5 cycles:
  - `stall_if`/`stall_id`/`stall_ex`=1 and `flush_mem`=1 each of those cycles.
  - `ex_hold`=0.
  - EX counter reads 5.
- `ex_req_stall`=1 and `mem_req_stall`=1 together:
  - MEM wins: `stall_mem`=1, `flush_wb`=1, `flush_mem`=0, `ex_hold`=1.
  - MEM counter increments; EX counter does not.
- `exc_req`=1 with `exc_target`=0xBFC00380 and `if_req_stall`=0:
  - Entry cycle: `flush_wb`=1.
  - Next cycle: `redirect_valid`=1, `redirect_pc`=0xBFC00380, all four flushes set.
- `exc_req` with `if_req_stall` held for 3 more cycles, target changed mid-`PEND`:
  - `redirect_valid` fires the cycle after `if_req_stall` drops.
  - `redirect_pc` carries the original target.
- `rst` asserted during `PEND`:
  - Immediately all outputs 0.
  - After release, state is `RUN`; `perf_data`=0 for every `perf_sel`.
- Preload the IF counter to 0xFFFFFFFF via a long IF stall run (or a forced value), then one more IF stall cycle: counter reads 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the five-stage pipeline stall/flush controller:
//   - pipe_state_e : controller FSM states (RUN / PEND / FLUSH)
//   - PERF_*       : perf_sel encodings, also used as stall-cause indices
//   - STG_*        : stage indices for the stall/flush strobe vectors
// ----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PEND  = 2'd1,
        FLUSH = 2'd2
    } pipe_state_e;

    // Counter select values; a stall cause is identified by the same code.
    localparam logic [1:0] PERF_IF  = 2'd0;
    localparam logic [1:0] PERF_EX  = 2'd1;
    localparam logic [1:0] PERF_MEM = 2'd2;
    localparam logic [1:0] PERF_EXC = 2'd3;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

endpackage

// File: rtl/pipe_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_if
// Bundle between the pipeline and the stall/flush controller.
//   master : pipeline side, drives stall requests, exception request/target
//            and the perf counter select; receives stage strobes.
//   slave  : controller side (pipe_ctrl).
// Signals:
//   if_req_stall / ex_req_stall / mem_req_stall : per-stage stall requests
//   exc_req, exc_target                         : exception redirect request
//   stall_* / flush_*                           : per-stage hold / bubble
//   ex_hold                                     : downstream hold to mul/div
//   redirect_valid, redirect_pc                 : PC redirect
//   perf_sel, perf_data                         : stall counter readout
// ----------------------------------------------------------------------------
interface pipe_ctrl_if #(
    parameter int W_PERF = 32
);
    logic              if_req_stall;
    logic              ex_req_stall;
    logic              mem_req_stall;
    logic              exc_req;
    logic [31:0]       exc_target;
    logic [1:0]        perf_sel;

    logic              stall_if;
    logic              stall_id;
    logic              stall_ex;
    logic              stall_mem;
    logic              stall_wb;
    logic              flush_id;
    logic              flush_ex;
    logic              flush_mem;
    logic              flush_wb;
    logic              ex_hold;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic [W_PERF-1:0] perf_data;

    modport master (
        output if_req_stall, ex_req_stall, mem_req_stall, exc_req, exc_target, perf_sel,
        input  stall_if, stall_id, stall_ex, stall_mem, stall_wb,
        input  flush_id, flush_ex, flush_mem, flush_wb,
        input  ex_hold, redirect_valid, redirect_pc, perf_data
    );

    modport slave (
        input  if_req_stall, ex_req_stall, mem_req_stall, exc_req, exc_target, perf_sel,
        output stall_if, stall_id, stall_ex, stall_mem, stall_wb,
        output flush_id, flush_ex, flush_mem, flush_wb,
        output ex_hold, redirect_valid, redirect_pc, perf_data
    );

endinterface

// File: rtl/pipe_ctrl_stall_counters.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_stall_counters
// Four wrapping stall-cycle counters (IF, EX, MEM, exception) with a
// combinational readout mux.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset (clears counters)
//   inc_en_i      : a cause won this cycle
//   inc_sel_i     : which counter to bump (PERF_* encoding)
//   perf_sel_i    : readout select
//   perf_data_o   : selected counter value
// ----------------------------------------------------------------------------
module pipe_ctrl_stall_counters
    import pipe_ctrl_pkg::*;
#(
    parameter int W_PERF = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_en_i,
    input  logic [1:0]        inc_sel_i,
    input  logic [1:0]        perf_sel_i,
    output logic [W_PERF-1:0] perf_data_o
);

    logic [W_PERF-1:0] cnt_q [4];

    // Only one cause is ever selected, so a single indexed increment suffices.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (inc_en_i) begin
            cnt_q[inc_sel_i] <= cnt_q[inc_sel_i] + W_PERF'(1);
        end
    end

    assign perf_data_o = cnt_q[perf_sel_i];

endmodule

// File: rtl/pipe_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_ctrl
// Central stall/flush controller for the IF/ID/EX/MEM/WB pipeline.
// Ports:
//   clk, rst : pipeline clock, asynchronous active-high reset
//   bus      : pipe_ctrl_if.slave (stall requests, exception request,
//              stage strobes, redirect, perf readout)
// Stage strobes are combinational from the requests and the FSM state.
// An exception freezes IF..MEM and bubbles WB, waits (PEND) for any
// outstanding fetch, then spends one FLUSH cycle bubbling ID..WB while the
// PC loads the latched target.
// ----------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int W_PERF = 32
) (
    input  logic     clk,
    input  logic     rst,
    pipe_ctrl_if.slave bus
);

    pipe_state_e state_q;
    logic [31:0] redirect_pc_q;

    logic [STG_WB:STG_IF] stall;
    logic [STG_WB:STG_ID] flush;
    logic                 redirect_valid;
    logic                 cnt_inc;
    logic [1:0]           cnt_sel;

    // FSM and exception target latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            redirect_pc_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.exc_req) begin
                        redirect_pc_q <= bus.exc_target;
                        state_q       <= bus.if_req_stall ? PEND : FLUSH;
                    end
                end
                PEND: begin
                    if (!bus.if_req_stall) begin
                        state_q <= FLUSH;
                    end
                end
                FLUSH:   state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

    // Strobe decode. Everything is forced low while reset is asserted, since
    // the request inputs may still be active then.
    always_comb begin
        stall          = '0;
        flush          = '0;
        redirect_valid = 1'b0;
        cnt_inc        = 1'b0;
        cnt_sel        = PERF_IF;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (bus.exc_req) begin
                        // Freeze IF..MEM and keep the excepting instruction from retiring.
                        stall[STG_MEM:STG_IF] = '1;
                        flush[STG_WB]         = 1'b1;
                        cnt_inc               = 1'b1;
                        cnt_sel               = PERF_EXC;
                    end else if (bus.mem_req_stall) begin
                        stall[STG_MEM:STG_IF] = '1;
                        flush[STG_WB]         = 1'b1;
                        cnt_inc               = 1'b1;
                        cnt_sel               = PERF_MEM;
                    end else if (bus.ex_req_stall) begin
                        stall[STG_EX:STG_IF]  = '1;
                        flush[STG_MEM]        = 1'b1;
                        cnt_inc               = 1'b1;
                        cnt_sel               = PERF_EX;
                    end else if (bus.if_req_stall) begin
                        stall[STG_IF]         = 1'b1;
                        flush[STG_ID]         = 1'b1;
                        cnt_inc               = 1'b1;
                        cnt_sel               = PERF_IF;
                    end
                end
                PEND: begin
                    stall[STG_MEM:STG_IF] = '1;
                    flush[STG_WB]         = 1'b1;
                    cnt_inc               = 1'b1;
                    cnt_sel               = PERF_EXC;
                end
                FLUSH: begin
                    flush          = '1;
                    redirect_valid = 1'b1;
                    cnt_inc        = 1'b1;
                    cnt_sel        = PERF_EXC;
                end
                default: begin
                    stall = '0;
                end
            endcase
        end
    end

    assign bus.stall_if       = stall[STG_IF];
    assign bus.stall_id       = stall[STG_ID];
    assign bus.stall_ex       = stall[STG_EX];
    assign bus.stall_mem      = stall[STG_MEM];
    assign bus.stall_wb       = stall[STG_WB];
    assign bus.flush_id       = flush[STG_ID];
    assign bus.flush_ex       = flush[STG_EX];
    assign bus.flush_mem      = flush[STG_MEM];
    assign bus.flush_wb       = flush[STG_WB];
    // Any MEM-level hold must also freeze the mul/div result in EX.
    assign bus.ex_hold        = stall[STG_MEM];
    assign bus.redirect_valid = redirect_valid;
    assign bus.redirect_pc    = redirect_pc_q;

    pipe_ctrl_stall_counters #(
        .W_PERF (W_PERF)
    ) u_stall_counters (
        .clk         (clk),
        .rst         (rst),
        .inc_en_i    (cnt_inc),
        .inc_sel_i   (cnt_sel),
        .perf_sel_i  (bus.perf_sel),
        .perf_data_o (bus.perf_data)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_ctrl
// Scoreboard bench for pipe_ctrl. A 32-bit instance and a 4-bit-counter
// instance (to reach counter wrap quickly) share the same stimulus.
// ----------------------------------------------------------------------------
module tb_pipe_ctrl;

    typedef struct packed {
        logic [4:0]  stall;   // {wb, mem, ex, id, if}
        logic [3:0]  flush;   // {wb, mem, ex, id}
        logic        hold;
        logic        rv;
        logic [31:0] pc;
        logic [31:0] perf;
        logic [3:0]  perf_s;
    } exp_t;

    logic clk;
    logic rst;

    pipe_ctrl_if #(.W_PERF(32)) ifm ();
    pipe_ctrl_if #(.W_PERF(4))  ifs ();

    pipe_ctrl #(.W_PERF(32)) dut   (.clk(clk), .rst(rst), .bus(ifm.slave));
    pipe_ctrl #(.W_PERF(4))  dut_s (.clk(clk), .rst(rst), .bus(ifs.slave));

    assign ifs.if_req_stall  = ifm.if_req_stall;
    assign ifs.ex_req_stall  = ifm.ex_req_stall;
    assign ifs.mem_req_stall = ifm.mem_req_stall;
    assign ifs.exc_req       = ifm.exc_req;
    assign ifs.exc_target    = ifm.exc_target;
    assign ifs.perf_sel      = ifm.perf_sel;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: exception bookkeeping and per-cause cycle tallies.
    bit          m_wait_fetch;   // exception taken, waiting for fetch to go idle
    bit          m_redirect;     // next cycle redirects the PC
    logic [31:0] m_target;
    logic [31:0] m_tally [4];    // 0 IF, 1 EX, 2 MEM, 3 exception

    task automatic cyc(input bit r, input bit ifr, input bit exr, input bit memr,
                       input bit exc, input logic [31:0] tgt, input logic [1:0] sel);
        exp_t e;
        int   cause;
        @(posedge clk);
        #1;
        rst               = r;
        ifm.if_req_stall  = ifr;
        ifm.ex_req_stall  = exr;
        ifm.mem_req_stall = memr;
        ifm.exc_req       = exc;
        ifm.exc_target    = tgt;
        ifm.perf_sel      = sel;

        e        = '0;
        cause    = -1;
        e.pc     = m_target;
        e.perf   = m_tally[sel];
        e.perf_s = m_tally[sel][3:0];
        if (r) begin
            m_wait_fetch = 0;
            m_redirect   = 0;
            m_target     = 0;
            for (int i = 0; i < 4; i++) m_tally[i] = 0;
            e.pc = 0; e.perf = 0; e.perf_s = 0;
        end else if (m_redirect) begin
            e.flush = 4'b1111; e.rv = 1'b1; cause = 3;
            m_redirect = 0;
        end else if (m_wait_fetch || exc) begin
            e.stall = 5'b01111; e.flush = 4'b1000; cause = 3;
            if (!m_wait_fetch) m_target = tgt;
            m_wait_fetch = ifr;
            m_redirect   = !ifr;
        end else if (memr) begin
            e.stall = 5'b01111; e.flush = 4'b1000; cause = 2;
        end else if (exr) begin
            e.stall = 5'b00111; e.flush = 4'b0100; cause = 1;
        end else if (ifr) begin
            e.stall = 5'b00001; e.flush = 4'b0001; cause = 0;
        end
        e.hold = e.stall[3];
        if (cause >= 0) m_tally[cause] = m_tally[cause] + 1;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input logic [1:0] sel);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 32'h0, sel);
    endtask

    // Monitor: compares one expected record per cycle away from the active edge.
    initial begin
        exp_t e;
        logic [9:0] got_str;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got_str = {ifm.stall_wb, ifm.stall_mem, ifm.stall_ex, ifm.stall_id, ifm.stall_if,
                           ifm.flush_wb, ifm.flush_mem, ifm.flush_ex, ifm.flush_id, ifm.ex_hold};
                total++;
                if (got_str !== {e.stall, e.flush, e.hold}) begin
                    bad++;
                    $display("FAIL strobes t=%0t got=%b want=%b", $time, got_str, {e.stall, e.flush, e.hold});
                end
                total++;
                if ({ifm.redirect_valid, ifm.redirect_pc} !== {e.rv, e.pc}) begin
                    bad++;
                    $display("FAIL redirect t=%0t got=%b/%h want=%b/%h", $time,
                             ifm.redirect_valid, ifm.redirect_pc, e.rv, e.pc);
                end
                total++;
                if (ifm.perf_data !== e.perf) begin
                    bad++;
                    $display("FAIL perf32 t=%0t sel=%0d got=%h want=%h", $time, ifm.perf_sel, ifm.perf_data, e.perf);
                end
                total++;
                if (ifs.perf_data !== e.perf_s) begin
                    bad++;
                    $display("FAIL perf4 t=%0t sel=%0d got=%h want=%h", $time, ifs.perf_sel, ifs.perf_data, e.perf_s);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        ifm.if_req_stall = 0; ifm.ex_req_stall = 0; ifm.mem_req_stall = 0;
        ifm.exc_req = 0; ifm.exc_target = 0; ifm.perf_sel = 0;
        m_wait_fetch = 0; m_redirect = 0; m_target = 0;
        for (int i = 0; i < 4; i++) m_tally[i] = 0;

        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 1, 32'hDEAD_BEEF, 2);   // requests active under reset
        // EX-only stall run, then read EX counter
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0, 0, 1);
        idle(1, 1);
        // EX and MEM together: MEM wins
        cyc(0, 0, 1, 1, 0, 0, 2);
        cyc(0, 1, 1, 1, 0, 0, 1);
        idle(1, 2); idle(1, 1);
        // Exception with idle fetch
        cyc(0, 0, 0, 0, 1, 32'hBFC0_0380, 3);
        idle(2, 3);
        // Exception with fetch outstanding; target changes while pending
        cyc(0, 1, 0, 0, 1, 32'h8000_0180, 3);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1, 1, 32'h1234_5678, 3);
        cyc(0, 0, 0, 0, 1, 32'h1234_5678, 3);
        idle(2, 3);
        // Reset while pending
        cyc(0, 1, 0, 0, 1, 32'hCAFE_0000, 3);
        cyc(0, 1, 0, 0, 0, 0, 3);
        cyc(1, 1, 0, 1, 1, 0, 3);
        for (int s = 0; s < 4; s++) idle(1, 2'(s));
        // IF counter wrap on the 4-bit instance (16 cycles -> 0)
        for (int i = 0; i < 16; i++) cyc(0, 1, 0, 0, 0, 0, 0);
        idle(1, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        idle(1, 0);
        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 120) == 0, ($urandom % 3) == 0, ($urandom % 4) == 0,
                ($urandom % 6) == 0, ($urandom % 12) == 0, $urandom, 2'($urandom % 4));
        end
        idle(2, 3);

        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
